// File: rtl/data_axi_master.sv
// AXI3 master for the CPU data side. It runs one read and one write channel concurrently, each either a single word or a cache-line burst.
// Optional feature macro DATA_AXI_CRITICAL_WORD_FIRST_EN: line reads become WRAP bursts that start at the requested word.
module data_axi_master #(
  parameter logic [3:0] AXI_ID     = 4'h1,
  parameter int         LINE_WORDS = 8,
  parameter int         IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  // cpu read side
  input  logic             rd_req,
  input  logic             rd_line,
  input  logic [31:0]      rd_addr,
  output logic             rd_ack,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic             rd_done,
  // cpu write side
  input  logic             wr_req,
  input  logic             wr_line,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  output logic             wr_ack,
  output logic             wr_beat,
  output logic             wr_done,
  // AXI3 read address
  output logic [3:0]       arid,
  output logic [31:0]      araddr,
  output logic [3:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [1:0]       arlock,
  output logic [3:0]       arcache,
  output logic [2:0]       arprot,
  output logic             arvalid,
  input  logic             arready,
  // AXI3 read data
  input  logic [3:0]       rid,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  // AXI3 write address
  output logic [3:0]       awid,
  output logic [31:0]      awaddr,
  output logic [3:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic [1:0]       awlock,
  output logic [3:0]       awcache,
  output logic [2:0]       awprot,
  output logic             awvalid,
  input  logic             awready,
  // AXI3 write data
  output logic [3:0]       wid,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  // AXI3 write response
  input  logic [3:0]       bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready,
  // FSM state for observation
  output logic [1:0]       rd_state,
  output logic [1:0]       wr_state
);

  // Handshake rule used on every channel: a transfer happens on a rising edge where valid and ready
  // are both high. A raised valid keeps its payload stable until that edge; ready never waits on valid.

  localparam int         OFF_W     = IDX_W + 2;
  localparam logic [3:0] BURST_LEN = 4'(LINE_WORDS - 1);

  typedef enum logic [1:0] {RIDLE = 2'd0, RADDR = 2'd1, RDATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WIDLE = 2'd0, WADDR = 2'd1, WDATA = 2'd2, WRESP = 2'd3} wr_state_t;

  rd_state_t        rd_st;
  wr_state_t        wr_st;
  logic [IDX_W-1:0] rd_cnt;
  logic [IDX_W-1:0] rd_start;
  logic [IDX_W-1:0] wr_cnt;
  logic             discard;

  logic [31:0] rd_phys;
  logic [31:0] wr_phys;
  logic        hazard;
  logic        rd_accept;
  logic        r_beat;
  logic        r_last;
  logic        deliver_off;
  logic        w_last;
  logic        b_hit;
  logic        unused_bits;

  assign rd_phys = {3'b000, rd_addr[28:0]};
  assign wr_phys = {3'b000, wr_addr[28:0]};

  // A read is held back while a write to the same line is still in progress.
  assign hazard      = (wr_st != WIDLE) && (rd_addr[28:OFF_W] == awaddr[28:OFF_W]);
  assign rd_accept   = (rd_st == RIDLE) && rd_req && !hazard && !flush;
  assign r_beat      = rready && rvalid && (rid == AXI_ID);
  assign r_last      = r_beat && (rlast || (4'(rd_cnt) == arlen));
  assign deliver_off = discard || flush;

  assign rd_ack   = arvalid && arready;
  assign rd_valid = r_beat && !deliver_off;
  assign rd_data  = rdata;
  assign rd_idx   = rd_start + rd_cnt;

  assign w_last  = (4'(wr_cnt) == awlen);
  assign wlast   = wvalid && w_last;
  assign wdata   = wr_data;
  assign wr_ack  = awvalid && awready;
  assign wr_beat = wvalid && wready;
  assign b_hit   = bready && bvalid && (bid == AXI_ID);
  assign wr_done = b_hit;

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'b000;
  assign awid    = AXI_ID;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'b000;
  assign wid     = AXI_ID;

  assign rd_state = rd_st;
  assign wr_state = wr_st;

  assign unused_bits = ^{rresp, bresp, rd_addr[31:29], wr_addr[31:29]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_st    <= RIDLE;
      arvalid  <= 1'b0;
      araddr   <= 32'h0;
      arlen    <= 4'h0;
      arburst  <= 2'b01;
      rready   <= 1'b0;
      rd_cnt   <= '0;
      rd_start <= '0;
      discard  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      rd_done <= r_last && !deliver_off;
      // The AXI burst always runs to completion; a flush only hides its data from the pipeline.
      if (flush && (rd_st != RIDLE))
        discard <= 1'b1;
      case (rd_st)
        RIDLE: begin
          discard <= 1'b0;
          if (rd_accept) begin
            rd_cnt  <= '0;
            arvalid <= 1'b1;
            rd_st   <= RADDR;
            if (rd_line) begin
              arlen <= BURST_LEN;
`ifdef DATA_AXI_CRITICAL_WORD_FIRST_EN
              araddr   <= {rd_phys[31:2], 2'b00};
              arburst  <= 2'b10;
              rd_start <= rd_addr[OFF_W-1:2];
`else
              araddr   <= {rd_phys[31:OFF_W], {OFF_W{1'b0}}};
              arburst  <= 2'b01;
              rd_start <= '0;
`endif
            end else begin
              arlen    <= 4'h0;
              araddr   <= rd_phys;
              arburst  <= 2'b01;
              rd_start <= '0;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            rd_st   <= RDATA;
          end
        end
        RDATA: begin
          if (r_beat)
            rd_cnt <= rd_cnt + 1'b1;
          if (r_last) begin
            rready  <= 1'b0;
            discard <= 1'b0;
            rd_st   <= RIDLE;
          end
        end
        default: rd_st <= RIDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_st   <= WIDLE;
      awvalid <= 1'b0;
      awaddr  <= 32'h0;
      awlen   <= 4'h0;
      wvalid  <= 1'b0;
      wstrb   <= 4'h0;
      wr_cnt  <= '0;
      bready  <= 1'b0;
    end else begin
      case (wr_st)
        WIDLE: begin
          if (wr_req) begin
            awvalid <= 1'b1;
            wr_cnt  <= '0;
            wr_st   <= WADDR;
            if (wr_line) begin
              awaddr <= {wr_phys[31:OFF_W], {OFF_W{1'b0}}};
              awlen  <= BURST_LEN;
              wstrb  <= 4'hF;
            end else begin
              awaddr <= wr_phys;
              awlen  <= 4'h0;
              wstrb  <= wr_strb;
            end
          end
        end
        WADDR: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            wr_st   <= WDATA;
          end
        end
        WDATA: begin
          if (wready) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (w_last) begin
              wvalid <= 1'b0;
              bready <= 1'b1;
              wr_st  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hit) begin
            bready <= 1'b0;
            wr_st  <= WIDLE;
          end
        end
        default: wr_st <= WIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_axi_master.sv
// Directed bench for data_axi_master: single/line reads, line-write hazard, flush discard, async reset mid-burst.
module tb_data_axi_master;

  localparam logic [3:0] ID = 4'h1;
`ifdef DATA_AXI_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk, resetn, flush;
  logic        rd_req, rd_line, rd_ack, rd_valid, rd_done;
  logic [31:0] rd_addr, rd_data;
  logic [2:0]  rd_idx;
  logic        wr_req, wr_line, wr_ack, wr_beat, wr_done;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rd_state, wr_state;

  int checks = 0;
  int errors = 0;

  data_axi_master #(.AXI_ID(ID), .LINE_WORDS(8), .IDX_W(3)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .rd_req(rd_req), .rd_line(rd_line), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx), .rd_done(rd_done),
    .wr_req(wr_req), .wr_line(wr_line), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .wr_ack(wr_ack), .wr_beat(wr_beat), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_state(rd_state), .wr_state(wr_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // driver: request a read and hold arready low for ar_delay cycles before the handshake
  task automatic issue_read(input logic [31:0] addr, input logic line, input logic [31:0] exp_addr,
                            input logic [1:0] exp_burst, input int ar_delay);
    rd_req = 1'b1; rd_line = line; rd_addr = addr;
    tick(); #1;
    check("arvalid", arvalid, 1);
    check("araddr", araddr, exp_addr);
    check("arlen", arlen, line ? 32'd7 : 32'd0);
    check("arburst", arburst, exp_burst);
    check("arsize", arsize, 3'b010);
    for (int k = 0; k < ar_delay; k++) begin
      check("rd_ack_early", rd_ack, 0);
      tick(); #1;
      check("arvalid_hold", arvalid, 1);
      check("araddr_hold", araddr, exp_addr);
    end
    arready = 1'b1; #1;
    check("rd_ack", rd_ack, 1);
    tick();
    rd_req = 1'b0; arready = 1'b0; #1;
    check("rready", rready, 1);
    check("arvalid_drop", arvalid, 0);
  endtask

  // driver: n read beats; flush pulses on beat quiet_from and delivery is suppressed from there on
  task automatic run_beats(input int n, input int start, input int quiet_from, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 2 == 1)) begin
        rvalid = 1'b0; #1;
        check("rd_valid_gap", rd_valid, 0);
        tick();
      end
      if (gaps && i == 3) begin
        rvalid = 1'b1; rid = 4'h2; rdata = 32'hDEAD_BEEF; #1;
        check("rd_valid_foreign", rd_valid, 0);
        tick();
      end
      rvalid = 1'b1; rid = ID; rdata = 32'hA500_0000 + i; rlast = (i == n - 1);
      flush = (i == quiet_from); #1;
      check("rd_valid", rd_valid, (i < quiet_from) ? 32'd1 : 32'd0);
      check("rready_beat", rready, 1);
      if (i < quiet_from) begin
        check("rd_idx", rd_idx, (start + i) % 8);
        check("rd_data", rd_data, 32'hA500_0000 + i);
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; flush = 1'b0; #1;
    check("rd_done", rd_done, (quiet_from >= n) ? 32'd1 : 32'd0);
    check("rready_end", rready, 0);
    tick(); #1;
    check("rd_done_pulse", rd_done, 0);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    rd_req = 1'b0; rd_line = 1'b0; rd_addr = 32'h0;
    wr_req = 1'b0; wr_line = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_strb = 4'h0;
    arready = 1'b0; rid = ID; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = ID; bresp = 2'b00; bvalid = 1'b0;

    repeat (2) tick();
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_wr_beat", wr_beat, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_states", {rd_state, wr_state}, 0);
    tick(); resetn = 1'b1; tick();

    // single read, arready delayed 3 cycles
    issue_read(32'hBFC0_0104, 1'b0, 32'h1FC0_0104, 2'b01, 3);
    run_beats(1, 0, 1, 1'b0);

    // line read with rvalid gaps and a foreign-ID beat
    issue_read(32'h8000_0014, 1'b1, CWF ? 32'h14 : 32'h0, CWF ? 2'b10 : 2'b01, 0);
    run_beats(8, CWF ? 5 : 0, 8, 1'b1);

    // line write with a same-line read waiting on it
    wr_req = 1'b1; wr_line = 1'b1; wr_addr = 32'h8000_1000; wr_strb = 4'h3;
    tick(); #1;
    check("awvalid", awvalid, 1);
    check("awaddr", awaddr, 32'h0000_1000);
    check("awlen", awlen, 7);
    check("awburst", awburst, 2'b01);
    check("wr_ack_early", wr_ack, 0);
    rd_req = 1'b1; rd_line = 1'b1; rd_addr = 32'h8000_1010; awready = 1'b1; #1;
    check("wr_ack", wr_ack, 1);
    tick();
    wr_req = 1'b0; awready = 1'b0; #1;
    check("wvalid", wvalid, 1);
    check("hazard_arvalid", arvalid, 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        wready = 1'b0; #1;
        check("wr_beat_stall", wr_beat, 0);
        tick();
      end
      wready = 1'b1; wr_data = 32'hD000_0000 + i; #1;
      check("wr_beat", wr_beat, 1);
      check("wdata", wdata, 32'hD000_0000 + i);
      check("wlast", wlast, (i == 7) ? 32'd1 : 32'd0);
      check("wstrb_line", wstrb, 4'hF);
      check("hazard_hold", arvalid, 0);
      tick();
    end
    wready = 1'b0; #1;
    check("bready", bready, 1);
    check("wvalid_end", wvalid, 0);
    bvalid = 1'b1; bid = 4'h3; #1;
    check("wr_done_foreign", wr_done, 0);
    tick();
    bid = ID; #1;
    check("wr_done", wr_done, 1);
    check("hazard_at_done", arvalid, 0);
    tick();
    bvalid = 1'b0; #1;
    check("wr_done_pulse", wr_done, 0);
    check("hazard_after_done", arvalid, 0);
    tick(); #1;
    check("ar_released", arvalid, 1);
    check("araddr_rel", araddr, CWF ? 32'h1010 : 32'h1000);
    arready = 1'b1; #1;
    check("rd_ack_rel", rd_ack, 1);
    tick();
    rd_req = 1'b0; arready = 1'b0;
    run_beats(8, CWF ? 4 : 0, 8, 1'b0);

    // single write with partial strobes
    wr_req = 1'b1; wr_line = 1'b0; wr_addr = 32'h8000_2004; wr_strb = 4'h3;
    tick();
    awready = 1'b1; #1;
    check("awaddr_single", awaddr, 32'h0000_2004);
    check("awlen_single", awlen, 0);
    check("wr_ack_single", wr_ack, 1);
    tick();
    wr_req = 1'b0; awready = 1'b0; wready = 1'b1; wr_data = 32'h1234_5678; #1;
    check("wr_beat_single", wr_beat, 1);
    check("wlast_single", wlast, 1);
    check("wstrb_single", wstrb, 4'h3);
    tick();
    wready = 1'b0; bvalid = 1'b1; #1;
    check("wr_done_single", wr_done, 1);
    tick();
    bvalid = 1'b0;

    // line read flushed at beat 3
    issue_read(32'h8000_0018, 1'b1, CWF ? 32'h18 : 32'h0, CWF ? 2'b10 : 2'b01, 1);
    run_beats(8, CWF ? 6 : 0, 3, 1'b0);
    rd_req = 1'b1; rd_line = 1'b0; rd_addr = 32'h8000_0040; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("flush_idle_block", arvalid, 0);
    issue_read(32'h8000_0040, 1'b0, 32'h40, 2'b01, 0);
    run_beats(1, 0, 1, 1'b0);

    // async reset during beat 4 of a line read
    issue_read(32'h8000_0100, 1'b1, 32'h100, CWF ? 2'b10 : 2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      rvalid = 1'b1; rid = ID; rdata = 32'hC000_0000 + i; #1;
      check("pre_rst_valid", rd_valid, 1);
      tick();
    end
    rvalid = 1'b1; #1;
    check("beat4_valid", rd_valid, 1);
    resetn = 1'b0; #1;
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_rready", rready, 0);
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_state", rd_state, 0);
    rvalid = 1'b0;
    tick(); resetn = 1'b1; tick();
    issue_read(32'h8000_0200, 1'b0, 32'h200, 2'b01, 0);
    run_beats(1, 0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
